ctrl_seq: RTL
=============

# ctrl_seq

Multi-channel clock-enable and reset sequencer for the simulation and test harness control path. It generalises the single clock/reset control of the existing harness to a parametrised number of channels. On a start request it holds every channel in reset for a programmable time, then releases the channels one by one with a fixed gap. Each released channel gets its own divided clock-enable strobe. It sits between the harness top and the DUT instances, one reset/enable pair per channel.

## Interface

Parameters:
- NUM_CH, 4, number of channels (≥1)
- DIV_W, 8, width of each channel divider value
- RST_CYC, 10, cycles all channel resets are held after start (≥1)
- GAP, 3, cycles between successive channel releases (≥1)

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  sequence request; sampled every cycle
- abort  input  1  stop request; returns to IDLE with all channels in reset
- div_cfg  input  NUM_CH*DIV_W  per-channel divider; channel k uses bits [k*DIV_W +: DIV_W]
- ch_rst  output  NUM_CH  per-channel reset, active-high
- ch_ce  output  NUM_CH  per-channel clock-enable strobe
- busy  output  1  high while the sequence is in ASSERT or RELEASE
- done  output  1  one-cycle pulse when the last channel is released

## Operation

- All outputs are registered.
- Reset values (rst high): state IDLE, ch_rst all ones, ch_ce all zeros, busy 0, done 0, internal counters 0.
- States and transitions:
  - **IDLE**: all channels are held in reset. start=1 moves to ASSERT and latches div_cfg into internal config registers. Later changes to div_cfg are ignored until the next accepted start.
  - **ASSERT**: all ch_rst are high. The counter runs 0..RST_CYC-1. On the last count, go to RELEASE and clear ch_rst[0].
  - **RELEASE**: the counter runs 0..GAP-1. On each expiry, clear ch_rst[idx+1]. When ch_rst[NUM_CH-1] clears, go to RUN and pulse done in that same cycle. With NUM_CH=1, ASSERT goes directly to RUN.
  - **RUN**: the channels free-run. start=1 restarts the sequence: latch div_cfg, set all ch_rst high, clear ch_ce, go to ASSERT.
- start is ignored in ASSERT and RELEASE.
- abort=1 in any state goes to IDLE the next cycle with all ch_rst high and ch_ce cleared. abort has priority over a simultaneous start, and that start is dropped.
- Divider for channel k (divider value div_k):
  - The counter is held at 0 while ch_rst[k]=1.
  - Once released, it counts 0..div_k and wraps. ch_ce[k]=1 in the cycle the count equals div_k.
  - div_k=0 gives ch_ce[k] constantly high after release.
- Widths:
  - Divider counters are DIV_W bits.
  - The sequence counter is wide enough for max(RST_CYC, GAP)-1.
  - The channel index is clog2(NUM_CH) bits, minimum 1.

## Timing

- Cycle numbering: start is sampled high at edge t; the first effects appear in cycle t+1.
- busy rises in cycle t+1.
- ch_rst[k] falls at cycle t+RST_CYC+k*GAP. ch_rst[0] falls at t+RST_CYC.
- done is high for exactly one cycle, coincident with the fall of ch_rst[NUM_CH-1]. busy falls in that same cycle.
- First ch_ce[k] pulse occurs div_k cycles after ch_rst[k] falls. The pulse period is div_k+1 cycles.
- Restart from RUN: all ch_rst are high and ch_ce is zero in cycle t+1. The release timing then repeats as above.
- abort sampled at edge a: all ch_rst are high and ch_ce, busy and done are 0 in cycle a+1.
- rst asserted mid-sequence: the reset values hold in the next cycle, regardless of start or abort.

## Test plan

Configuration for all scenarios: NUM_CH=4, RST_CYC=10, GAP=3, div_cfg={7,3,1,0} (channel 3..0).

1. Reset, then a start pulse at edge 0.
   - ch_rst falls at cycles 10, 13, 16 and 19.
   - done is high only in cycle 19; busy is high in cycles 1..18.
2. Run after scenario 1.
   - ch_ce[0] is high from cycle 10 onward.
   - ch_ce[1] is high in cycles 14, 16, ….
   - ch_ce[2] is high in cycles 19, 23, ….
   - ch_ce[3] is high in cycles 26, 34, ….
3. Start pulses at cycles 5 and 12 during the sequence.
   - Both are ignored; the timing is identical to scenario 1.
4. abort at cycle 14 during RELEASE.
   - From cycle 15: all ch_rst high, ch_ce 0, busy 0, and no done.
   - A following start gives a clean sequence.
5. In RUN, change div_cfg to all 2, then pulse start.
   - All resets re-assert the next cycle, and the full sequence repeats.
   - Every channel's ch_ce period is 3 after its release.
6. start and abort together in IDLE, then rst mid-ASSERT.
   - Simultaneous start and abort: stays in IDLE.
   - rst mid-ASSERT: reset values appear the next cycle, and no channel is released.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-channel reset/clock-enable sequencer: holds all channels in reset after
// a start, releases them one by one, then gives each its own divided strobe.
module ctrl_seq #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 8,
  parameter int RST_CYC = 10,
  parameter int GAP     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic [NUM_CH-1:0]       ch_ce,
  output logic                    busy,
  output logic                    done
);

  localparam int MAX_CYC  = (RST_CYC > GAP) ? RST_CYC : GAP;
  localparam int CNT_W    = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // ASSERT occupies RST_CYC-1 cycles so ch_rst[0] falls RST_CYC cycles after start
  localparam int AST_LAST = (RST_CYC >= 2) ? RST_CYC - 2 : 0;
  localparam int IDX_LAST = (NUM_CH >= 2) ? NUM_CH - 2 : 0;

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, RUN} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [NUM_CH-1:0]        rst_nxt, ce_nxt;
  logic                     busy_nxt, done_nxt, load_cfg;
  logic [DIV_W-1:0]         dcnt     [NUM_CH];
  logic [DIV_W-1:0]         dcnt_nxt [NUM_CH];
  logic [DIV_W-1:0]         cfg      [NUM_CH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rst_nxt   = ch_rst;
    done_nxt  = 1'b0;
    load_cfg  = 1'b0;
    case (state)
      IDLE: begin
        rst_nxt = '1;
        cnt_nxt = '0;
        idx_nxt = '0;
        if (start) begin
          state_nxt = ASSERT;
          load_cfg  = 1'b1;
        end
      end
      ASSERT: begin
        if (cnt == CNT_W'(AST_LAST)) begin
          cnt_nxt    = '0;
          idx_nxt    = '0;
          rst_nxt[0] = 1'b0;
          if (NUM_CH == 1) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RELEASE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == CNT_W'(GAP - 1)) begin
          cnt_nxt = '0;
          idx_nxt = idx + 1'b1;
          for (int k = 1; k < NUM_CH; k++) begin
            if (k == int'(idx) + 1) rst_nxt[k] = 1'b0;
          end
          if (idx == IDX_W'(IDX_LAST)) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          state_nxt = ASSERT;
          rst_nxt   = '1;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          load_cfg  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides everything, including a start in the same cycle
    if (abort) begin
      state_nxt = IDLE;
      rst_nxt   = '1;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      done_nxt  = 1'b0;
      load_cfg  = 1'b0;
    end
    busy_nxt = (state_nxt == ASSERT) || (state_nxt == RELEASE);
    // Dividers restart from 0 on the release cycle so the first strobe lands div_k later
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst_nxt[k] || ch_rst[k])  dcnt_nxt[k] = '0;
      else if (dcnt[k] == cfg[k])   dcnt_nxt[k] = '0;
      else                          dcnt_nxt[k] = dcnt[k] + 1'b1;
      ce_nxt[k] = !rst_nxt[k] && (dcnt_nxt[k] == cfg[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      ch_rst <= '1;
      ch_ce  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) dcnt[k] <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      ch_rst <= rst_nxt;
      ch_ce  <= ce_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      for (int k = 0; k < NUM_CH; k++) dcnt[k] <= dcnt_nxt[k];
    end
  end

  always_ff @(posedge clk) begin
    if (load_cfg && !rst) begin
      for (int k = 0; k < NUM_CH; k++) cfg[k] <= div_cfg[k*DIV_W +: DIV_W];
    end
  end

endmodule
